// File: rtl/mult_accum_clamp.sv
// mult_accum_clamp: repeated-addition multiplier with limit clamp; define MULT_SWAP_EN to add the operand-ordering ORDER state
module mult_accum_clamp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] limit,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             clamped
);
`ifdef MULT_SWAP_EN
  typedef enum logic [1:0] {IDLE, ORDER, ACCUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, addend_q, addend_d, acc_q, acc_d, lim_q, lim_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic clamped_q, clamped_d;
  logic [WIDTH:0] sum;
  assign sum = {1'b0, acc_q} + {1'b0, addend_q};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addend_d = addend_q;
    acc_d = acc_q;
    lim_d = lim_q;
    result_d = result_q;
    clamped_d = clamped_q;
    case (state_q)
      IDLE: if (start) begin
        cnt_d = a;
        addend_d = b;
        acc_d = '0;
        lim_d = limit;
        result_d = '0;
        clamped_d = 1'b0;
`ifdef MULT_SWAP_EN
        state_d = ORDER;
`else
        state_d = ACCUM;
`endif
      end
`ifdef MULT_SWAP_EN
      ORDER: begin
        cnt_d = (cnt_q > addend_q) ? addend_q : cnt_q;
        addend_d = (cnt_q > addend_q) ? cnt_q : addend_q;
        state_d = ACCUM;
      end
`endif
      ACCUM: if (cnt_q == '0) begin
        result_d = acc_q;
        state_d = DONE;
      end else if (sum > {1'b0, lim_q}) begin
        result_d = lim_q;
        clamped_d = 1'b1;
        state_d = DONE;
      end else begin
        acc_d = sum[WIDTH-1:0];
        cnt_d = cnt_q - WIDTH'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addend_q <= '0;
      acc_q <= '0;
      lim_q <= '0;
      result_q <= '0;
      clamped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addend_q <= addend_d;
      acc_q <= acc_d;
      lim_q <= lim_d;
      result_q <= result_d;
      clamped_q <= clamped_d;
    end
  end
  assign ready = state_q == IDLE;
  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = state_q == DONE;
  assign result = result_q;
  assign clamped = clamped_q;
endmodule
